gpr_write_arbiter: RTL

GPR_WRITE_ARBITER -- requirements
Module: gpr_write_arbiter

---
 rtl/gpr_write_arbiter_pkg.sv | 24 ++
 rtl/gpr_write_arbiter_wb_fifo.sv | 76 +++++++
 rtl/gpr_write_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/gpr_write_arbiter_pkg.sv
// Shared constants for the GPR writeback arbiter: source indices and default widths.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package gpr_write_arbiter_pkg;

  // Writeback source indices, matching the GPR write-select ordering.
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC  = 2;
  localparam int SRC_MDU = 3;

  // Default geometry.
  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_FIFO_DEPTH = 2;

  // Source index visited at position 'offset' of a round-robin scan that starts
  // just after 'last'.
  function automatic int rr_index(input int last, input int offset, input int n);
    return (last + 1 + offset) % n;
  endfunction

endpackage

// File: rtl/gpr_write_arbiter_wb_fifo.sv
// Per-source writeback queue with count-based full/empty and an associative key lookup.
// Latency: a push is visible at the head the cycle after its edge; a pop removes it on its edge.
// Backpressure: pushes while full and pops while empty are ignored; clr empties it on an edge.
//
// Ports: clk, rst_n (async active-low); clr (synchronous empty); push/push_dat;
//        pop; head_dat (oldest entry); empty/full; query_key -> query_hit
//        (any valid entry whose top KEY_W bits equal query_key).
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int KEY_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full,
  input  logic [KEY_W-1:0] query_key,
  output logic             query_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;
  logic [PW-1:0]    slot_off;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: validity comes only from count.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    query_hit = 1'b0;
    slot_off  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_off = PW'(j) - rd_ptr;
      if ((CW'(slot_off) < count) && (mem[j][WIDTH-1 -: KEY_W] == query_key))
        query_hit = 1'b1;
    end
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Merges per-source GPR writebacks through small queues onto one registered write port.
// Latency: accept at edge N, gpr_we high after edge N+1 when uncontended (one write per cycle).
// Backpressure: src_ready = queue not full and no flush; a pop never frees space in the same cycle.
//
// Ports: clk, rst_n (async active-low); src_valid/src_ready/src_addr/src_data
//        (packed per source, source i at [i*W +: W]); flush; query_addr -> query_hit;
//        gpr_we/gpr_waddr/gpr_wdata (registered write port); busy.
module gpr_write_arbiter
  import gpr_write_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*REG_AW-1:0]  src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic                       flush,
  input  logic [REG_AW-1:0]          query_addr,
  output logic                       query_hit,
  output logic                       gpr_we,
  output logic [REG_AW-1:0]          gpr_waddr,
  output logic [DATA_W-1:0]          gpr_wdata,
  output logic                       busy
);

  localparam int ENT_W = REG_AW + DATA_W;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_pop;
  logic [NUM_SRC-1:0] fifo_hit;
  logic [ENT_W-1:0]   head_dat [NUM_SRC];

  logic [SRC_W-1:0]   last_grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [ENT_W-1:0]   grant_ent;
  logic [REG_AW-1:0]  grant_addr;
  logic [DATA_W-1:0]  grant_data;

  assign src_ready = ~fifo_full & {NUM_SRC{~flush}};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign fifo_pop[i] = !flush && grant_vld && (grant_idx == SRC_W'(i));

    wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W),
      .KEY_W (REG_AW)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .push      (src_valid[i] && src_ready[i]),
      .push_dat  ({src_addr[i*REG_AW +: REG_AW], src_data[i*DATA_W +: DATA_W]}),
      .pop       (fifo_pop[i]),
      .head_dat  (head_dat[i]),
      .empty     (fifo_empty[i]),
      .full      (fifo_full[i]),
      .query_key (query_addr),
      .query_hit (fifo_hit[i])
    );
  end

  // Scan from the furthest candidate back to the nearest so the nearest
  // non-empty source after last_grant is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!fifo_empty[rr_index(int'(last_grant), k, NUM_SRC)]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(rr_index(int'(last_grant), k, NUM_SRC));
      end
    end
  end

  assign grant_ent  = head_dat[grant_idx];
  assign grant_addr = grant_ent[ENT_W-1 -: REG_AW];
  assign grant_data = grant_ent[DATA_W-1:0];

  // Writes to r0 are drained silently and do not advance the round-robin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= LAST_INIT;
      gpr_we     <= 1'b0;
      gpr_waddr  <= '0;
      gpr_wdata  <= '0;
    end else if (flush) begin
      gpr_we <= 1'b0;
    end else if (grant_vld && (grant_addr != '0)) begin
      gpr_we     <= 1'b1;
      gpr_waddr  <= grant_addr;
      gpr_wdata  <= grant_data;
      last_grant <= grant_idx;
    end else begin
      gpr_we <= 1'b0;
    end
  end

  assign query_hit = (query_addr != '0) &&
                     ((|fifo_hit) || (gpr_we && (gpr_waddr == query_addr)));
  assign busy      = (~&fifo_empty) || gpr_we;

endmodule
